dcache_wb: RTL and testbench

Direct-mapped, write-back, write-allocate data cache that sits between the MEM-stage data port (`WB_Data_WB`) and a line-wide main-memory port. It serves loads and stores in a single cycle on a hit. On a miss it raises `miss`, which the hazard unit uses to stall the whole pipeline. While `miss` is high it writes back a dirty victim line if needed, refills the line, and then completes the access. It also keeps hit and miss counters for the CPI experiments.

---
 rtl/dcache_wb_if.sv | 32 +++
 rtl/dcache_wb.sv | 132 +++++++++++++
 tb/tb_dcache_wb.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/dcache_wb_if.sv
// Core-side and memory-side signal bundle for dcache_wb.
// The slave modport is the cache's view; the master modport is the view of the core and memory.
interface dcache_wb_if #(
  parameter int LINE_ADDR_LEN = 3
);
  localparam int LINE_W = 32 * (2 ** LINE_ADDR_LEN);

  logic [31:0]       addr;
  logic              rd_req;
  logic [3:0]        wr_req;
  logic [31:0]       wr_data;
  logic [31:0]       rd_data;
  logic              miss;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  modport slave (
    input  addr, rd_req, wr_req, wr_data, mem_rdata, mem_ready,
    output rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );

  modport master (
    output addr, rd_req, wr_req, wr_data, mem_rdata, mem_ready,
    input  rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache with a line-wide memory port.
// A miss stalls the pipeline while the victim is written back and the line is refilled.
module dcache_wb #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 2,
  parameter int TAG_ADDR_LEN  = 25
) (
  input logic        clk,
  input logic        rst,
  dcache_wb_if.slave bus
);
  localparam int WORDS   = 2 ** LINE_ADDR_LEN;
  localparam int SETS    = 2 ** SET_ADDR_LEN;
  localparam int SET_LSB = LINE_ADDR_LEN + 2;
  localparam int TAG_LSB = SET_LSB + SET_ADDR_LEN;
  localparam int LINE_W  = 32 * WORDS;

  typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;

  state_t r_state;
  state_t w_next;

  logic [SETS-1:0]         r_valid;
  logic [SETS-1:0]         r_dirty;
  logic [TAG_ADDR_LEN-1:0] r_tag  [SETS];
  logic [31:0]             r_data [SETS][WORDS];
  logic                    r_after_fill;
  logic [31:0]             r_hit_cnt;
  logic [31:0]             r_miss_cnt;

  logic [LINE_ADDR_LEN-1:0] w_off;
  logic [SET_ADDR_LEN-1:0]  w_set;
  logic [TAG_ADDR_LEN-1:0]  w_tag;
  logic                     w_store;
  logic                     w_req;
  logic                     w_hit;
  logic                     w_fill;
  logic [LINE_W-1:0]        w_victim;
  logic                     w_unused;

  assign w_off    = bus.addr[SET_LSB-1:2];
  assign w_set    = bus.addr[TAG_LSB-1:SET_LSB];
  assign w_tag    = bus.addr[31:TAG_LSB];
  assign w_unused = &{1'b0, bus.addr[1:0]};

  assign w_store = |bus.wr_req;
  assign w_req   = bus.rd_req | w_store;
  assign w_hit   = w_req && r_valid[w_set] && (r_tag[w_set] == w_tag) && (r_state == IDLE);
  assign w_fill  = (r_state == SWAP_IN) && bus.mem_ready;

  assign bus.rd_data  = w_hit ? r_data[w_set][w_off] : '0;
  assign bus.miss     = w_req && !w_hit;
  assign bus.hit_cnt  = r_hit_cnt;
  assign bus.miss_cnt = r_miss_cnt;

  always_comb begin
    w_victim = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      w_victim[w*32 +: 32] = r_data[w_set][w];
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.miss) begin
          w_next = (r_valid[w_set] && r_dirty[w_set]) ? SWAP_OUT : SWAP_IN;
        end
      end
      SWAP_OUT:   if (bus.mem_ready) w_next = SWAP_IN;
      SWAP_IN:    if (bus.mem_ready) w_next = SWAP_IN_OK;
      SWAP_IN_OK: w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (r_state)
      SWAP_OUT: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {r_tag[w_set], w_set, {SET_LSB{1'b0}}};
        bus.mem_wdata = w_victim;
      end
      SWAP_IN: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {w_tag, w_set, {SET_LSB{1'b0}}};
      end
      default: ;
    endcase
  end

  // r_after_fill marks the IDLE cycle that completes a refilled access, already counted as a miss.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_after_fill <= 1'b0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_state      <= w_next;
      r_after_fill <= (r_state == SWAP_IN_OK);
      if (w_hit && !r_after_fill) r_hit_cnt <= r_hit_cnt + 32'd1;
      if ((r_state == IDLE) && bus.miss) r_miss_cnt <= r_miss_cnt + 32'd1;
      if (w_hit && w_store) r_dirty[w_set] <= 1'b1;
      if (w_fill) begin
        r_valid[w_set] <= 1'b1;
        r_dirty[w_set] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_set] <= w_tag;
      for (int unsigned w = 0; w < WORDS; w++) begin
        r_data[w_set][w] <= bus.mem_rdata[w*32 +: 32];
      end
    end else if (w_hit && w_store) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.wr_req[b]) r_data[w_set][w_off][b*8 +: 8] <= bus.wr_data[b*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb with a 5-cycle line-wide memory model.
module tb_dcache_wb;
  localparam int LAT    = 5;
  localparam int LINE_W = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   stall = 1'b0;
  bit   inited = 1'b0;
  int   cnt = 0;
  int   errors = 0;
  int   checks = 0;

  logic [LINE_W-1:0] mem_line [16];

  dcache_wb_if #(.LINE_ADDR_LEN(3)) bus ();

  dcache_wb #(
    .LINE_ADDR_LEN(3),
    .SET_ADDR_LEN (2),
    .TAG_ADDR_LEN (25)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem_line[bus.mem_addr[8:5]];

  // Memory model: mem_ready pulses in the LAT-th cycle of an uninterrupted request.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      if (!inited) begin
        for (int l = 0; l < 16; l++)
          for (int w = 0; w < 8; w++)
            mem_line[l][w*32 +: 32] <= 32'h1000_0000 | (l << 8) | w;
        mem_line[0][159:128] <= 32'hDEADBEEF;
        mem_line[4][159:128] <= 32'hCAFEF00D;
        inited <= 1'b1;
      end
      cnt           <= 0;
      bus.mem_ready <= 1'b0;
    end else if (!bus.mem_req || bus.mem_ready) begin
      if (bus.mem_req && bus.mem_ready && bus.mem_we) mem_line[bus.mem_addr[8:5]] <= bus.mem_wdata;
      cnt           <= 0;
      bus.mem_ready <= 1'b0;
    end else if (!stall) begin
      if (cnt == LAT - 2) bus.mem_ready <= 1'b1;
      else cnt <= cnt + 1;
    end
  end

  task automatic run_access(input logic [31:0] a, output int cyc, output logic saw_we,
                            output logic [31:0] wb_addr, output logic [31:0] wb_w4,
                            output logic [31:0] rf_addr);
    bus.addr = a; bus.rd_req = 1'b1; bus.wr_req = 4'b0000;
    cyc = 0; saw_we = 1'b0; wb_addr = '1; wb_w4 = '0; rf_addr = '1;
    #1;
    while (bus.miss && cyc < 200) begin
      if (bus.mem_req && bus.mem_we) begin
        saw_we = 1'b1; wb_addr = bus.mem_addr; wb_w4 = bus.mem_wdata[159:128];
      end
      if (bus.mem_req && !bus.mem_we) rf_addr = bus.mem_addr;
      cyc++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset;
    bus.addr = '0; bus.rd_req = 1'b0; bus.wr_req = 4'b0000; bus.wr_data = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.hit_cnt !== 32'd0) begin errors++; $display("FAIL reset_hit_cnt got=%0h exp=0", bus.hit_cnt); end
    checks++; if (bus.miss_cnt !== 32'd0) begin errors++; $display("FAIL reset_miss_cnt got=%0h exp=0", bus.miss_cnt); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%0b exp=0", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr got=%0h exp=0", bus.mem_addr); end
    checks++; if (bus.rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data got=%0h exp=0", bus.rd_data); end
    checks++; if (bus.miss !== 1'b0) begin errors++; $display("FAIL reset_miss_idle got=%0b exp=0", bus.miss); end
    bus.addr = 32'h10; bus.rd_req = 1'b1; #1;
    checks++; if (bus.miss !== 1'b1) begin errors++; $display("FAIL reset_miss_req got=%0b exp=1", bus.miss); end
    bus.rd_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cold_read;
    int cyc; logic we; logic [31:0] wa, w4, ra;
    run_access(32'h10, cyc, we, wa, w4, ra);
    checks++; if (cyc !== 7) begin errors++; $display("FAIL cold_miss_cycles got=%0d exp=7", cyc); end
    checks++; if (ra !== 32'h0) begin errors++; $display("FAIL cold_refill_addr got=%0h exp=0", ra); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL cold_no_writeback got=%0b exp=0", we); end
    checks++; if (bus.rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL cold_rd_data got=%0h exp=deadbeef", bus.rd_data); end
    checks++; if (bus.miss_cnt !== 32'd1) begin errors++; $display("FAIL cold_miss_cnt got=%0d exp=1", bus.miss_cnt); end
    @(negedge clk); bus.rd_req = 1'b0; #1;
    checks++; if (bus.hit_cnt !== 32'd0) begin errors++; $display("FAIL cold_hit_cnt got=%0d exp=0", bus.hit_cnt); end
  endtask

  task automatic test_store_hit;
    bus.addr = 32'h10; bus.wr_req = 4'b0011; bus.wr_data = 32'h12345678; #1;
    checks++; if (bus.miss !== 1'b0) begin errors++; $display("FAIL store_miss got=%0b exp=0", bus.miss); end
    @(negedge clk); bus.wr_req = 4'b0000; #1;
    checks++; if (bus.hit_cnt !== 32'd1) begin errors++; $display("FAIL store_hit_cnt got=%0d exp=1", bus.hit_cnt); end
    bus.rd_req = 1'b1; #1;
    checks++; if (bus.rd_data !== 32'hDEAD5678) begin errors++; $display("FAIL store_readback got=%0h exp=dead5678", bus.rd_data); end
    @(negedge clk); bus.rd_req = 1'b0; #1;
    checks++; if (bus.hit_cnt !== 32'd2) begin errors++; $display("FAIL load_hit_cnt got=%0d exp=2", bus.hit_cnt); end
  endtask

  task automatic test_dirty_evict;
    int cyc; logic we; logic [31:0] wa, w4, ra;
    run_access(32'h90, cyc, we, wa, w4, ra);
    checks++; if (cyc !== 12) begin errors++; $display("FAIL dirty_miss_cycles got=%0d exp=12", cyc); end
    checks++; if (wa !== 32'h0) begin errors++; $display("FAIL dirty_wb_addr got=%0h exp=0", wa); end
    checks++; if (w4 !== 32'hDEAD5678) begin errors++; $display("FAIL dirty_wb_word4 got=%0h exp=dead5678", w4); end
    checks++; if (ra !== 32'h80) begin errors++; $display("FAIL dirty_refill_addr got=%0h exp=80", ra); end
    checks++; if (bus.rd_data !== 32'hCAFEF00D) begin errors++; $display("FAIL dirty_rd_data got=%0h exp=cafef00d", bus.rd_data); end
    checks++; if (bus.miss_cnt !== 32'd2) begin errors++; $display("FAIL dirty_miss_cnt got=%0d exp=2", bus.miss_cnt); end
    @(negedge clk); bus.rd_req = 1'b0;
  endtask

  task automatic test_clean_evict;
    int cyc; logic we; logic [31:0] wa, w4, ra;
    run_access(32'h10, cyc, we, wa, w4, ra);
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL clean_mem_we got=%0b exp=0", we); end
    checks++; if (cyc !== 7) begin errors++; $display("FAIL clean_miss_cycles got=%0d exp=7", cyc); end
    checks++; if (bus.rd_data !== 32'hDEAD5678) begin errors++; $display("FAIL clean_rd_data got=%0h exp=dead5678", bus.rd_data); end
    checks++; if (bus.miss_cnt !== 32'd3) begin errors++; $display("FAIL clean_miss_cnt got=%0d exp=3", bus.miss_cnt); end
    @(negedge clk); bus.rd_req = 1'b0;
  endtask

  task automatic test_load_store_same_cycle;
    bus.addr = 32'h10; bus.rd_req = 1'b1; bus.wr_req = 4'b1100; bus.wr_data = 32'hBEEF0000; #1;
    checks++; if (bus.rd_data !== 32'hDEAD5678) begin errors++; $display("FAIL ldst_pre_store got=%0h exp=dead5678", bus.rd_data); end
    @(negedge clk); bus.wr_req = 4'b0000; #1;
    checks++; if (bus.rd_data !== 32'hBEEF5678) begin errors++; $display("FAIL ldst_post_store got=%0h exp=beef5678", bus.rd_data); end
    @(negedge clk); bus.rd_req = 1'b0; #1;
    checks++; if (bus.hit_cnt !== 32'd4) begin errors++; $display("FAIL ldst_hit_cnt got=%0d exp=4", bus.hit_cnt); end
  endtask

  task automatic test_reset_mid_refill;
    int cyc, n; logic we; logic [31:0] wa, w4, ra;
    bus.addr = 32'h30; bus.rd_req = 1'b1; #1;
    n = 0;
    while (!bus.mem_req && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rmid_reach_swapin got=%0b exp=1", bus.mem_req); end
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rmid_mem_req got=%0b exp=0", bus.mem_req); end
    checks++; if (bus.miss !== 1'b1) begin errors++; $display("FAIL rmid_miss got=%0b exp=1", bus.miss); end
    checks++; if (bus.miss_cnt !== 32'd0) begin errors++; $display("FAIL rmid_miss_cnt_clr got=%0d exp=0", bus.miss_cnt); end
    checks++; if (bus.hit_cnt !== 32'd0) begin errors++; $display("FAIL rmid_hit_cnt_clr got=%0d exp=0", bus.hit_cnt); end
    @(negedge clk); rst = 1'b1;
    run_access(32'h10, cyc, we, wa, w4, ra);
    checks++; if (cyc !== 7) begin errors++; $display("FAIL rmid_miss_cycles got=%0d exp=7", cyc); end
    checks++; if (bus.rd_data !== 32'hDEAD5678) begin errors++; $display("FAIL rmid_rd_data got=%0h exp=dead5678", bus.rd_data); end
    checks++; if (bus.miss_cnt !== 32'd1) begin errors++; $display("FAIL rmid_miss_cnt got=%0d exp=1", bus.miss_cnt); end
    @(negedge clk); bus.rd_req = 1'b0; #1;
    checks++; if (bus.hit_cnt !== 32'd0) begin errors++; $display("FAIL rmid_hit_cnt got=%0d exp=0", bus.hit_cnt); end
  endtask

  task automatic test_stalled_memory;
    int n;
    stall = 1'b1;
    bus.addr = 32'h50; bus.rd_req = 1'b1; #1;
    n = 0;
    while (!bus.mem_req && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (bus.mem_addr !== 32'h40) begin errors++; $display("FAIL stall_mem_addr got=%0h exp=40", bus.mem_addr); end
    for (int i = 0; i < 50; i++) begin
      checks++;
      if ({bus.miss, bus.mem_req, bus.mem_we, bus.mem_addr} !== {3'b110, 32'h40}) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got=%b/%b/%b/%0h exp=1/1/0/40", i, bus.miss, bus.mem_req, bus.mem_we, bus.mem_addr);
      end
      @(negedge clk); #1;
    end
    stall = 1'b0;
    n = 0;
    while (bus.miss && n < 50) begin @(negedge clk); #1; n++; end
    checks++; if (n !== 6) begin errors++; $display("FAIL stall_release_cycles got=%0d exp=6", n); end
    checks++; if (bus.rd_data !== 32'h10000204) begin errors++; $display("FAIL stall_rd_data got=%0h exp=10000204", bus.rd_data); end
    @(negedge clk); bus.rd_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_store_hit();
    test_dirty_evict();
    test_clean_evict();
    test_load_store_same_cycle();
    test_reset_mid_refill();
    test_stalled_memory();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
